w_start_fifo: RTL and testbench
===============================

// Module: w_start_fifo
// PURPOSE
//  Entry stage of the SHA-256 miner pipeline: accepts 16-word message blocks,
//  optionally patches the nonce word from an internal counter, and buffers up to
//  DEPTH blocks. Blocks leave towards the W-expansion/round stages on a
//  valid/ready handshake, so a stalled core back-pressures the block source.
// PARAMETERS
//  WORD_W    32  bits per message word
//  NWORDS    16  words per block; W_in/W width = NWORDS*WORD_W (= `WARR_S)
//  DEPTH     4   FIFO entries; power of two, >= 2
//  NONCE_EN  1   1 = overwrite word NONCE_IDX with nonce counter on push
//  NONCE_IDX 3   index of nonce word, 0..NWORDS-1
// PORTS
//  clk           in   1                  rising-edge clock
//  reset         in   1                  asynchronous, active-high
//  en            in   1                  input valid
//  in_ready      out  1                  FIFO can accept (= !full)
//  W_in          in   NWORDS*WORD_W      block; word i at [(i+1)*WORD_W-1 : i*WORD_W]
//  nonce_load    in   1                  load nonce counter from nonce_init
//  nonce_init    in   WORD_W             nonce load value
//  W             out  NWORDS*WORD_W      head-of-FIFO block
//  en_next       out  1                  output valid (= !empty)
//  ready_next    in   1                  downstream accepts
//  count         out  $clog2(DEPTH+1)    entries held
//  nonce         out  WORD_W             current nonce counter value
//  nonce_wrapped out  1                  sticky: counter wrapped all-ones -> 0
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers, count, nonce, nonce_wrapped = 0;
//    storage = 0, so W = 0; en_next = 0; in_ready = 1.
//  - push = en & in_ready; pop = en_next & ready_next. en while !in_ready: block
//    dropped, no state change; source must hold en/W_in until in_ready.
//  - Latency: push on edge k -> en_next=1 and W valid from edge k (visible in
//    cycle k+1) when FIFO was empty. No combinational in->out path.
//  - W is storage[rd_ptr]; it and en_next hold stable while en_next & !ready_next.
//  - Simultaneous push+pop (0<count<DEPTH): count unchanged, both pointers advance.
//    Full: in_ready=0, pop only; push accepted next cycle after pop.
//    Empty: pop impossible; ready_next ignored.
//  - Pointers are $clog2(DEPTH) bits, wrap DEPTH-1 -> 0; count in 0..DEPTH.
//  - Nonce (NONCE_EN=1): on push, stored word NONCE_IDX = nonce_eff, other words
//    = W_in. nonce_eff = nonce_load ? nonce_init : nonce. Next nonce:
//    push ? nonce_eff+1 (mod 2^WORD_W) : nonce_eff. nonce_load also clears
//    nonce_wrapped; wrap (nonce_eff all-ones & push) sets it, set wins over clear.
//  - NONCE_EN=0: W_in stored unmodified; nonce counter only follows nonce_load.
//  - Reset mid-transfer: all buffered blocks discarded, en_next=0 asynchronously.
// STRUCTURE
//  - sha.vh: WORD_W, NWORDS, `WARR_S, word-slice macro; shared with W_expand/rounds.
//  - One sub-module: nonce_ctr (load/increment/wrap flag), instanced when NONCE_EN.
//  - FIFO storage, pointers and count in this module; storage reg array, no RAM.
// TESTING
//  1 Reset: assert reset mid-cycle -> en_next=0, count=0, W=0, in_ready=1 at once.
//  2 Single block, NONCE_EN=1, nonce_load nonce_init=32'h1000 one cycle before:
//    push W_in word3=32'hDEAD -> next cycle en_next=1, W word3=32'h1000,
//    other words = W_in, nonce=32'h1001.
//  3 Fill: ready_next=0, push 5 blocks -> 4 accepted, count=4, in_ready=0, 5th
//    held by source; raise ready_next -> blocks exit in order 0..3, then 4.
//  4 Concurrent: count=2, push+pop for 10 cycles -> count stays 2, order kept,
//    pointers wrap past 3 without data loss.
//  5 Nonce wrap: nonce_init=32'hFFFF_FFFF, load+push same cycle -> stored
//    word3=32'hFFFF_FFFF, nonce=0, nonce_wrapped=1; next nonce_load clears it.
//  6 Reset with count=3, ready_next=1 -> buffered blocks gone, no further en_next.

Source files
------------

// File: rtl/w_start_fifo_pkg.sv
// Shared constants and FIFO operation decoding for the SHA-256 miner entry stage.
package w_start_fifo_pkg;

  localparam int WORD_W_DEF    = 32;
  localparam int NWORDS_DEF    = 16;
  localparam int DEPTH_DEF     = 4;
  localparam int NONCE_IDX_DEF = 3;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/w_start_fifo_nonce_ctr.sv
// Nonce counter: load from init, increment on each accepted block, sticky wrap flag.
module w_start_fifo_nonce_ctr
  import w_start_fifo_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] init,
  input  logic              inc,
  output logic [WORD_W-1:0] nonce_eff,
  output logic [WORD_W-1:0] nonce,
  output logic              wrapped
);

  logic [WORD_W-1:0] nonce_d, nonce_q;
  logic              wrapped_d, wrapped_q;

  always_comb begin
    nonce_eff = load ? init : nonce_q;
    nonce_d   = inc ? nonce_eff + WORD_W'(1) : nonce_eff;
    wrapped_d = wrapped_q;
    if (load) wrapped_d = 1'b0;
    // A wrap in the same cycle as a load must remain visible.
    if (inc && (&nonce_eff)) wrapped_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nonce_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      nonce_q   <= nonce_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign nonce   = nonce_q;
  assign wrapped = wrapped_q;

endmodule

// File: rtl/w_start_fifo.sv
// Entry FIFO of the SHA-256 miner: buffers message blocks, patches the nonce word
// on push, and hands blocks downstream over a valid/ready handshake.
module w_start_fifo
  import w_start_fifo_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NWORDS    = NWORDS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int NONCE_EN  = 1,
  parameter int NONCE_IDX = NONCE_IDX_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  output logic                         in_ready,
  input  logic [NWORDS*WORD_W-1:0]     W_in,
  input  logic                         nonce_load,
  input  logic [WORD_W-1:0]            nonce_init,
  output logic [NWORDS*WORD_W-1:0]     W,
  output logic                         en_next,
  input  logic                         ready_next,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WORD_W-1:0]            nonce,
  output logic                         nonce_wrapped
);

  localparam int BLK_W = NWORDS * WORD_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [BLK_W-1:0] storage_d [DEPTH];
  logic [BLK_W-1:0] storage_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             push, pop;
  logic [WORD_W-1:0] nonce_eff;
  logic [BLK_W-1:0]  blk_in;

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign en_next  = (count_q != '0);
  assign push     = en && in_ready;
  assign pop      = en_next && ready_next;
  assign W        = storage_q[rd_ptr_q];
  assign count    = count_q;

  if (NONCE_EN != 0) begin : g_nonce
    w_start_fifo_nonce_ctr #(.WORD_W(WORD_W)) u_nonce_ctr (
      .clk       (clk),
      .reset     (reset),
      .load      (nonce_load),
      .init      (nonce_init),
      .inc       (push),
      .nonce_eff (nonce_eff),
      .nonce     (nonce),
      .wrapped   (nonce_wrapped)
    );
  end else begin : g_no_nonce
    logic [WORD_W-1:0] plain_nonce_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) plain_nonce_q <= '0;
      else if (nonce_load) plain_nonce_q <= nonce_init;
    end

    assign nonce_eff     = plain_nonce_q;
    assign nonce         = plain_nonce_q;
    assign nonce_wrapped = 1'b0;
  end

  always_comb begin
    blk_in = W_in;
    if (NONCE_EN != 0) blk_in[NONCE_IDX*WORD_W +: WORD_W] = nonce_eff;
  end

  always_comb begin
    storage_d = storage_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      storage_d[wr_ptr_q] = blk_in;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case (fifo_op(push, pop))
      OP_PUSH: count_d = count_q + CNT_W'(1);
      OP_POP:  count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      storage_q <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      storage_q <= storage_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_w_start_fifo.sv
// Directed bench for w_start_fifo: table of single-cycle vectors plus hand sequences.
module tb_w_start_fifo;

  localparam int WORD_W = 32;
  localparam int NWORDS = 16;
  localparam int BLK_W  = WORD_W * NWORDS;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             in_ready;
  logic [BLK_W-1:0] W_in;
  logic             nonce_load;
  logic [31:0]      nonce_init;
  logic [BLK_W-1:0] W;
  logic             en_next;
  logic             ready_next;
  logic [2:0]       count;
  logic [31:0]      nonce;
  logic             nonce_wrapped;

  int tests  = 0;
  int errors = 0;

  w_start_fifo #(
    .WORD_W(32), .NWORDS(16), .DEPTH(4), .NONCE_EN(1), .NONCE_IDX(3)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .in_ready(in_ready), .W_in(W_in),
    .nonce_load(nonce_load), .nonce_init(nonce_init), .W(W), .en_next(en_next),
    .ready_next(ready_next), .count(count), .nonce(nonce), .nonce_wrapped(nonce_wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        ld;
    logic [31:0] init;
    logic [15:0] tag;
    logic [2:0]  cnt;
    logic        vld;
    logic        irdy;
    logic [31:0] nonce;
    logic        chk_w;
    logic [31:0] w3;
    logic [31:0] w0;
  } vec_t;

  vec_t vec [12];

  typedef struct {
    logic [15:0] tag;
    logic [31:0] w3;
  } ent_t;

  ent_t        q[$];
  logic [31:0] nonce_m;

  function automatic logic [BLK_W-1:0] mk_blk(input logic [15:0] tag);
    logic [BLK_W-1:0] b;
    for (int i = 0; i < NWORDS; i++) b[i*WORD_W +: WORD_W] = {tag, 16'(i)};
    b[3*WORD_W +: WORD_W] = 32'hDEAD;
    return b;
  endfunction

  function automatic logic [31:0] word(input logic [BLK_W-1:0] b, input int i);
    return b[i*WORD_W +: WORD_W];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic r, input logic ld,
                      input logic [31:0] init, input logic [15:0] tag);
    en = e; ready_next = r; nonce_load = ld; nonce_init = init; W_in = mk_blk(tag);
    @(posedge clk);
    #1;
  endtask

  // Check every other word of the head block as well as the patched one.
  task automatic chk_head(input string name, input logic [15:0] tag, input logic [31:0] w3);
    logic [BLK_W-1:0] exp;
    exp = mk_blk(tag);
    exp[3*WORD_W +: WORD_W] = w3;
    tests++;
    if (W !== exp) begin
      errors++;
      $display("FAIL %s: head w0=%h w3=%h, expected w0=%h w3=%h",
               name, word(W, 0), word(W, 3), word(exp, 0), w3);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; ready_next = 1'b0; nonce_load = 1'b0;
    nonce_init = '0; W_in = '0;

    vec[0]  = '{0, 0, 1, 32'h1000, 16'h0, 3'd0, 0, 1, 32'h1000, 1, 32'h0,    32'h0};
    vec[1]  = '{1, 0, 0, 32'h0,    16'h1, 3'd1, 1, 1, 32'h1001, 1, 32'h1000, 32'h0001_0000};
    vec[2]  = '{1, 0, 0, 32'h0,    16'h2, 3'd2, 1, 1, 32'h1002, 1, 32'h1000, 32'h0001_0000};
    vec[3]  = '{1, 0, 0, 32'h0,    16'h3, 3'd3, 1, 1, 32'h1003, 1, 32'h1000, 32'h0001_0000};
    vec[4]  = '{1, 0, 0, 32'h0,    16'h4, 3'd4, 1, 0, 32'h1004, 1, 32'h1000, 32'h0001_0000};
    vec[5]  = '{1, 0, 0, 32'h0,    16'h5, 3'd4, 1, 0, 32'h1004, 1, 32'h1000, 32'h0001_0000};
    vec[6]  = '{1, 1, 0, 32'h0,    16'h5, 3'd3, 1, 1, 32'h1004, 1, 32'h1001, 32'h0002_0000};
    vec[7]  = '{1, 1, 0, 32'h0,    16'h5, 3'd3, 1, 1, 32'h1005, 1, 32'h1002, 32'h0003_0000};
    vec[8]  = '{0, 1, 0, 32'h0,    16'h0, 3'd2, 1, 1, 32'h1005, 1, 32'h1003, 32'h0004_0000};
    vec[9]  = '{0, 1, 0, 32'h0,    16'h0, 3'd1, 1, 1, 32'h1005, 1, 32'h1004, 32'h0005_0000};
    vec[10] = '{0, 1, 0, 32'h0,    16'h0, 3'd0, 0, 1, 32'h1005, 0, 32'h0,    32'h0};
    vec[11] = '{0, 1, 0, 32'h0,    16'h0, 3'd0, 0, 1, 32'h1005, 0, 32'h0,    32'h0};

    // Reset state, then a mid-cycle asynchronous reset with a block buffered.
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, 0, 0, 32'h0, 16'h77);
    chk("pre_rst_count", 32'(count), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("arst_en_next", 32'(en_next), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_W_zero", 32'(W != '0), 32'd0);
    chk("arst_nonce", nonce, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single block with nonce patch, then fill / drain with backpressure.
    for (int i = 0; i < 12; i++) begin
      step(vec[i].en, vec[i].rdy, vec[i].ld, vec[i].init, vec[i].tag);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vec[i].cnt));
      chk($sformatf("v%0d_en_next", i), 32'(en_next), 32'(vec[i].vld));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vec[i].irdy));
      chk($sformatf("v%0d_nonce", i), nonce, vec[i].nonce);
      if (vec[i].chk_w) begin
        chk($sformatf("v%0d_w3", i), word(W, 3), vec[i].w3);
        chk($sformatf("v%0d_w0", i), word(W, 0), vec[i].w0);
      end
    end

    // Concurrent push+pop at count=2 across pointer wrap.
    nonce_m = 32'h1005;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 32'h0, 16'(16'h10 + i));
      q.push_back('{16'(16'h10 + i), nonce_m});
      nonce_m = nonce_m + 1;
    end
    chk("cc_fill_count", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 32'h0, 16'(16'h12 + i));
      void'(q.pop_front());
      q.push_back('{16'(16'h12 + i), nonce_m});
      nonce_m = nonce_m + 1;
      chk($sformatf("cc%0d_count", i), 32'(count), 32'd2);
      chk_head($sformatf("cc%0d_head", i), q[0].tag, q[0].w3);
    end
    for (int i = 0; i < 2; i++) begin
      chk_head($sformatf("cc_drain%0d_head", i), q[0].tag, q[0].w3);
      step(0, 1, 0, 32'h0, 16'h0);
      void'(q.pop_front());
    end
    chk("cc_drain_count", 32'(count), 32'd0);
    chk("cc_nonce", nonce, nonce_m);

    // Nonce wrap: load all-ones and push in the same cycle.
    step(1, 0, 1, 32'hFFFF_FFFF, 16'h40);
    chk("wrap_w3", word(W, 3), 32'hFFFF_FFFF);
    chk("wrap_w0", word(W, 0), 32'h0040_0000);
    chk("wrap_nonce", nonce, 32'h0);
    chk("wrap_flag", 32'(nonce_wrapped), 32'd1);
    step(0, 0, 0, 32'h0, 16'h0);
    chk("wrap_flag_sticky", 32'(nonce_wrapped), 32'd1);
    step(0, 1, 1, 32'h5, 16'h0);
    chk("wrap_clear_flag", 32'(nonce_wrapped), 32'd0);
    chk("wrap_clear_nonce", nonce, 32'h5);
    chk("wrap_drained", 32'(count), 32'd0);

    // Reset with three blocks buffered and downstream ready.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 16'(16'h50 + i));
    chk("r6_count", 32'(count), 32'd3);
    en = 1'b0; ready_next = 1'b1;
    #3 reset = 1'b1;
    #1;
    chk("r6_en_next", 32'(en_next), 32'd0);
    chk("r6_count0", 32'(count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 32'h0, 16'h0);
      chk($sformatf("r6_idle%0d_en_next", i), 32'(en_next), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
